// File: rtl/seq_pkg.sv
// Package seq_pkg: shared types and constants for the note sequencer.
//   seq_state_e  - sequencer FSM states (IDLE, LOAD, PLAY)
//   NOTE_W/LEN_W - field widths of a pattern entry
//   PERIOD_TABLE - note code -> tone counter period (code 0 = rest = 0)
//   note_of/len_of - field extractors for an 8-bit pattern entry
package seq_pkg;

  localparam int NOTE_W = 4;
  localparam int LEN_W  = 4;
  localparam int ENTRY_W = NOTE_W + LEN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

  localparam logic [7:0] PERIOD_TABLE [0:15] = '{
    8'd0,   8'd239, 8'd226, 8'd213, 8'd201, 8'd190, 8'd179, 8'd169,
    8'd160, 8'd151, 8'd142, 8'd134, 8'd127, 8'd119, 8'd113, 8'd106
  };

  function automatic logic [NOTE_W-1:0] note_of(input logic [ENTRY_W-1:0] e);
    return e[ENTRY_W-1:LEN_W];
  endfunction

  function automatic logic [LEN_W-1:0] len_of(input logic [ENTRY_W-1:0] e);
    return e[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Interface note_sequencer_if: all non-clock/reset signals of the note sequencer.
// Optional feature macro: SEQ_LOOP_EN adds the 'loop' control input.
//   control : start, stop, tempo_tick, last_step, (loop)
//   write   : wr_en, wr_addr, wr_data  ([7:4] note, [3:0] len)
//   outputs : period, gate, step, note_start, busy, done, dbg_state
// Modports: master = pattern/control source, slave = sequencer.
// Signalling: start/stop/last_step/loop are levels sampled every clk; tempo_tick
// and wr_en are 1-clk strobes acted on at the rising edge they are seen; there is
// no backpressure (no ready), every strobe is accepted in the cycle it is high.
interface note_sequencer_if #(
  parameter int STEPS  = 16,
  parameter int STEP_W = $clog2(STEPS)
);
  import seq_pkg::*;

  logic              start;
  logic              stop;
  logic              tempo_tick;
  logic [STEP_W-1:0] last_step;
`ifdef SEQ_LOOP_EN
  logic              loop;
`endif
  logic              wr_en;
  logic [STEP_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        period;
  logic              gate;
  logic [STEP_W-1:0] step;
  logic              note_start;
  logic              busy;
  logic              done;
  seq_state_e        dbg_state;

  modport master (
`ifdef SEQ_LOOP_EN
    output loop,
`endif
    output start, stop, tempo_tick, last_step, wr_en, wr_addr, wr_data,
    input  period, gate, step, note_start, busy, done, dbg_state
  );

  modport slave (
`ifdef SEQ_LOOP_EN
    input  loop,
`endif
    input  start, stop, tempo_tick, last_step, wr_en, wr_addr, wr_data,
    output period, gate, step, note_start, busy, done, dbg_state
  );

endinterface

// File: rtl/seq_pattern_ram.sv
// seq_pattern_ram: STEPS x 8-bit pattern register file.
//   clk, reset       - clock, asynchronous active-high reset (clears all entries)
//   wr_en/addr/data  - synchronous write port
//   rd_addr/rd_data  - asynchronous read port (returns pre-write contents in
//                      the cycle of a write to the same address)
module seq_pattern_ram #(
  parameter int STEPS  = 16,
  parameter int STEP_W = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [STEP_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [STEPS];
  logic [7:0] mem_d [STEPS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) mem_q[i] <= 8'h00;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: pattern-driven step sequencer feeding a tone counter.
// Optional feature macro: SEQ_LOOP_EN (end of pattern with loop=1 restarts at step 0).
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - note_sequencer_if.slave (control, pattern write port, outputs)
// Each step: LOAD (1 clk) reads entry[step] and drives period/gate, then PLAY
// counts len+1 tempo ticks before moving on. gate is left untouched across
// LOAD so consecutive notes do not glitch the counter enable.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int STEPS  = 16,
  parameter int STEP_W = $clog2(STEPS)
) (
  input  logic           clk,
  input  logic           reset,
  note_sequencer_if.slave bus
);

  logic [7:0]        rd_data;

  seq_state_e        state_q,      state_d;
  logic [STEP_W-1:0] step_q,       step_d;
  logic [LEN_W-1:0]  remaining_q,  remaining_d;
  logic [7:0]        period_q,     period_d;
  logic              gate_q,       gate_d;
  logic              note_start_q, note_start_d;
  logic              done_q,       done_d;
  logic              loop_en;

`ifdef SEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
`endif

  seq_pattern_ram #(.STEPS(STEPS), .STEP_W(STEP_W)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (step_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    remaining_d  = remaining_q;
    period_d     = period_q;
    gate_d       = gate_q;
    note_start_d = 1'b0;
    done_d       = 1'b0;

    if (bus.stop) begin
      state_d = ST_IDLE;
      gate_d  = 1'b0;
    end else if (bus.start) begin
      // Start from any state (re)begins playback; gate keeps its value.
      state_d = ST_LOAD;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          remaining_d  = len_of(rd_data);
          period_d     = PERIOD_TABLE[note_of(rd_data)];
          gate_d       = (note_of(rd_data) != '0);
          note_start_d = 1'b1;
          state_d      = ST_PLAY;
        end
        ST_PLAY: begin
          if (bus.tempo_tick) begin
            if (remaining_q != '0) begin
              remaining_d = remaining_q - 1'b1;
            end else if (step_q < bus.last_step) begin
              step_d  = step_q + STEP_W'(1);
              state_d = ST_LOAD;
            end else if (loop_en) begin
              // step > last_step (shrunk mid-play) also lands here.
              step_d  = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
              gate_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      remaining_q  <= '0;
      period_q     <= 8'h00;
      gate_q       <= 1'b0;
      note_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      remaining_q  <= remaining_d;
      period_q     <= period_d;
      gate_q       <= gate_d;
      note_start_q <= note_start_d;
      done_q       <= done_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.gate       = gate_q;
  assign bus.step       = step_q;
  assign bus.note_start = note_start_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed testbench for note_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point (away from the edge).
module tb_note_sequencer;

  localparam int STEPS  = 16;
  localparam int STEP_W = 4;

  // Expected periods for the note codes used below.
  localparam logic [7:0] P1 = 8'd239;
  localparam logic [7:0] P2 = 8'd226;
  localparam logic [7:0] P3 = 8'd213;
  localparam logic [7:0] P4 = 8'd201;
  localparam logic [7:0] P5 = 8'd190;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  note_sequencer_if #(.STEPS(STEPS), .STEP_W(STEP_W)) sif ();

  note_sequencer #(.STEPS(STEPS), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sif.tempo_tick = 1'b1;
    cyc();
    sif.tempo_tick = 1'b0;
  endtask

  task automatic wr(input logic [STEP_W-1:0] a, input logic [7:0] d);
    sif.wr_en   = 1'b1;
    sif.wr_addr = a;
    sif.wr_data = d;
    cyc();
    sif.wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    sif.start  = 1'b0;
    sif.stop   = 1'b0;
    sif.tempo_tick = 1'b0;
    sif.last_step  = '0;
    sif.wr_en   = 1'b0;
    sif.wr_addr = '0;
    sif.wr_data = 8'h00;
`ifdef SEQ_LOOP_EN
    sif.loop    = 1'b0;
`endif
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    chk("rst_period", sif.period, 0);
    chk("rst_gate", sif.gate, 0);
    chk("rst_step", sif.step, 0);
    chk("rst_note_start", sif.note_start, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);

    // Reset mid-PLAY clears outputs at once and wipes the pattern
    wr(0, 8'h35); wr(1, 8'h45); wr(2, 8'h55); wr(3, 8'h65);
    sif.last_step = 3;
    pulse_start();
    cyc();
    chk("mid_gate_before", sif.gate, 1);
    chk("mid_period_before", sif.period, P3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_period", sif.period, 0);
    chk("mid_rst_gate", sif.gate, 0);
    chk("mid_rst_busy", sif.busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("clr_period", sif.period, 0);
      chk("clr_gate", sif.gate, 0);
      chk("clr_step", sif.step, i);
      tick();
    end
    chk("clr_done", sif.done, 1);
    cyc();

    // Single step: 8'h12 -> note 1, 3 ticks
    wr(0, 8'h12);
    sif.last_step = 0;
    pulse_start();
    chk("ss_busy_load", sif.busy, 1);
    chk("ss_ns_load", sif.note_start, 0);
    cyc();
    chk("ss_period", sif.period, P1);
    chk("ss_gate", sif.gate, 1);
    chk("ss_note_start", sif.note_start, 1);
    cyc();
    chk("ss_ns_drop", sif.note_start, 0);
    tick();
    tick();
    chk("ss_gate_t2", sif.gate, 1);
    chk("ss_done_t2", sif.done, 0);
    tick();
    chk("ss_gate_end", sif.gate, 0);
    chk("ss_done_end", sif.done, 1);
    chk("ss_busy_end", sif.busy, 0);
    chk("ss_period_hold", sif.period, P1);
    cyc();
    chk("ss_done_drop", sif.done, 0);

    // Rest handling: 30, 00, 50
    wr(0, 8'h30); wr(1, 8'h00); wr(2, 8'h50);
    sif.last_step = 2;
    pulse_start();
    cyc();
    chk("rest_s0_step", sif.step, 0);
    chk("rest_s0_gate", sif.gate, 1);
    chk("rest_s0_period", sif.period, P3);
    tick();
    chk("rest_load_gate_hold", sif.gate, 1);
    chk("rest_load_step", sif.step, 1);
    tick();  // arrives in LOAD, ignored
    chk("rest_s1_gate", sif.gate, 0);
    chk("rest_s1_period", sif.period, 0);
    chk("rest_s1_ns", sif.note_start, 1);
    tick();
    chk("rest_s2_step", sif.step, 2);
    chk("rest_s2_load_gate", sif.gate, 0);
    cyc();
    chk("rest_s2_gate", sif.gate, 1);
    chk("rest_s2_period", sif.period, P5);
    tick();
    chk("rest_done", sif.done, 1);
    chk("rest_gate_end", sif.gate, 0);
    cyc();

    // Stop has priority over start
    wr(0, 8'h13);
    sif.last_step = 0;
    pulse_start();
    cyc();
    tick();
    sif.stop  = 1'b1;
    sif.start = 1'b1;
    cyc();
    sif.stop  = 1'b0;
    sif.start = 1'b0;
    chk("stop_gate", sif.gate, 0);
    chk("stop_busy", sif.busy, 0);
    chk("stop_done", sif.done, 0);
    chk("stop_period_hold", sif.period, P1);
    cyc();
    chk("stop_done_later", sif.done, 0);
    chk("stop_busy_later", sif.busy, 0);

    // Restart at step 3
    wr(0, 8'h10); wr(1, 8'h20); wr(2, 8'h30); wr(3, 8'h40);
    sif.last_step = 7;
    pulse_start();
    cyc();
    tick(); cyc();
    tick(); cyc();
    tick(); cyc();
    chk("rs_step3", sif.step, 3);
    chk("rs_period3", sif.period, P4);
    pulse_start();
    chk("rs_step0", sif.step, 0);
    chk("rs_busy", sif.busy, 1);
    chk("rs_gate_hold", sif.gate, 1);
    cyc();
    chk("rs_ns", sif.note_start, 1);
    chk("rs_period0", sif.period, P1);

    // last_step lowered below the current step ends the pattern
    tick(); cyc();
    tick(); cyc();
    tick(); cyc();
    chk("shr_step3", sif.step, 3);
    sif.last_step = 1;
    tick();
    chk("shr_done", sif.done, 1);
    chk("shr_gate", sif.gate, 0);
    chk("shr_busy", sif.busy, 0);
    cyc();

`ifdef SEQ_LOOP_EN
    // Loop: 0,1,0,1 without done, then drop loop
    sif.loop = 1'b1;
    sif.last_step = 1;
    pulse_start();
    cyc();
    chk("lp_step_a", sif.step, 0);
    tick(); cyc();
    chk("lp_step_b", sif.step, 1);
    chk("lp_period_b", sif.period, P2);
    tick();
    chk("lp_wrap_step", sif.step, 0);
    chk("lp_wrap_done", sif.done, 0);
    chk("lp_wrap_busy", sif.busy, 1);
    cyc();
    chk("lp_ns_c", sif.note_start, 1);
    chk("lp_period_c", sif.period, P1);
    tick(); cyc();
    chk("lp_step_d", sif.step, 1);
    sif.loop = 1'b0;
    tick();
    chk("lp_end_done", sif.done, 1);
    chk("lp_end_busy", sif.busy, 0);
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
